// File: rtl/pixel_line_buffer.sv
`timescale 1ns/1ps
// Ping-pong line store between the host pixel stream and the SPI line transmitter.
// The host fills one bank while the transmitter reads the other. Banks swap only
// between transmitter sessions, so a line is never torn mid-transmission.
module pixel_line_buffer #(
  parameter int unsigned ADD_WIDTH  = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned REPEAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [31:0]          wr_data,
  input  logic                 wr_last,
  output logic                 wr_ready,
  input  logic [ADD_WIDTH-1:0] rd_address,
  output logic [32:0]          pixel,
  output logic [ADD_WIDTH:0]   pixel_count,
  output logic                 tx_rst,
  input  logic                 tx_done,
  output logic                 line_dropped
);

  localparam int unsigned DEPTH  = 1 << ADD_WIDTH;
  localparam int unsigned CNT_W  = ADD_WIDTH + 1;
  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SHOW} state_e;

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 fill_q, fill_d;
  logic [ADD_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                 pending_q, pending_d;
  logic [CNT_W-1:0]     pend_count_q, pend_count_d;
  logic [CNT_W-1:0]     pixel_count_q, pixel_count_d;
  logic                 tx_rst_q, tx_rst_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 line_dropped_q, line_dropped_d;
  logic                 tx_done_q, tx_done_d;
  logic [32:0]          pixel_q, pixel_d;

  logic                 accept;
  logic                 commit;
  logic                 done_rise;
  logic                 swap;

  // Both banks in one array; the bank select bit is the address MSB.
  logic [31:0] mem [0:2*DEPTH-1];

  // Next-state for the session FSM, bank pointer, write pointer and outputs.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    swap           = 1'b0;
    accept         = wr_valid & wr_ready_q;
    commit         = accept & (wr_last | (wr_ptr_q == '1));
    done_rise      = tx_done & ~tx_done_q;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          swap       = 1'b1;
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = ST_SHOW;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (done_rise) begin
          hold_cnt_d = '0;
          if (pending_q) begin
            swap    = 1'b1;
            state_d = ST_HOLD;
          end else if (REPEAT != 0) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fill_d        = swap ? ~fill_q : fill_q;
    pixel_count_d = swap ? pend_count_q : pixel_count_q;

    // A commit coinciding with a swap landed in the bank now being shown: it is lost.
    if (swap || commit) begin
      wr_ptr_d = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (swap) begin
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    pend_count_d   = (commit && !swap) ? (CNT_W'(wr_ptr_q) + CNT_W'(1)) : pend_count_q;
    line_dropped_d = commit & pending_q;
    // wr_ready follows pending with one cycle of lag; the shadow cycle right after
    // a commit is what allows a commit to coincide with the swap.
    wr_ready_d     = ~pending_q;
    tx_rst_d       = (state_d != ST_SHOW);
    tx_done_d      = tx_done;
    pixel_d        = {({1'b0, rd_address} < pixel_count_q), mem[{~fill_q, rd_address}]};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hold_cnt_q     <= '0;
      fill_q         <= 1'b0;
      wr_ptr_q       <= '0;
      pending_q      <= 1'b0;
      pend_count_q   <= '0;
      pixel_count_q  <= '0;
      tx_rst_q       <= 1'b1;
      wr_ready_q     <= 1'b1;
      line_dropped_q <= 1'b0;
      tx_done_q      <= 1'b0;
      pixel_q        <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      fill_q         <= fill_d;
      wr_ptr_q       <= wr_ptr_d;
      pending_q      <= pending_d;
      pend_count_q   <= pend_count_d;
      pixel_count_q  <= pixel_count_d;
      tx_rst_q       <= tx_rst_d;
      wr_ready_q     <= wr_ready_d;
      line_dropped_q <= line_dropped_d;
      tx_done_q      <= tx_done_d;
      pixel_q        <= pixel_d;
    end
  end

  // Host word write into the fill bank; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[{fill_q, wr_ptr_q}] <= wr_data;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign pixel        = pixel_q;
  assign pixel_count  = pixel_count_q;
  assign tx_rst       = tx_rst_q;
  assign line_dropped = line_dropped_q;

endmodule

// File: tb/tb_pixel_line_buffer.sv
`timescale 1ns/1ps
// Directed bench for pixel_line_buffer: one REPEAT=1 and one REPEAT=0 instance on shared inputs.
module tb_pixel_line_buffer;

  localparam int unsigned AW = 8;
  localparam int unsigned RC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_last = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic          tx_done = 1'b0;

  logic          wr_ready, tx_rst, line_dropped;
  logic [32:0]   pixel;
  logic [AW:0]   pixel_count;

  logic          wr_ready_nr, tx_rst_nr, line_dropped_nr;
  logic [32:0]   pixel_nr;
  logic [AW:0]   pixel_count_nr;

  int n_cmp = 0;
  int n_bad = 0;
  int hold_n;

  pixel_line_buffer #(.ADD_WIDTH(AW), .RST_CYCLES(RC), .REPEAT(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .rd_address(rd_address), .pixel(pixel), .pixel_count(pixel_count),
    .tx_rst(tx_rst), .tx_done(tx_done), .line_dropped(line_dropped)
  );

  pixel_line_buffer #(.ADD_WIDTH(AW), .RST_CYCLES(RC), .REPEAT(0)) dut_nr (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready_nr), .rd_address(rd_address), .pixel(pixel_nr),
    .pixel_count(pixel_count_nr), .tx_rst(tx_rst_nr), .tx_done(tx_done),
    .line_dropped(line_dropped_nr)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic read_px(input logic [AW-1:0] a);
    rd_address = a;
    @(negedge clk);
  endtask

  task automatic wait_show(input string tag);
    for (int i = 0; i < 40 && tx_rst !== 1'b0; i++) @(negedge clk);
    check(tag, 64'(tx_rst), 64'd0);
  endtask

  // Raise tx_done for one cycle and count the cycles tx_rst stays high afterwards.
  task automatic pulse_done_count(output int n);
    n = 0;
    tx_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_rst === 1'b1) n++;
      else break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_pixel", 64'(pixel), 64'd0);
    check("rst_count", 64'(pixel_count), 64'd0);
    check("rst_tx_rst", 64'(tx_rst), 64'd1);
    check("rst_dropped", 64'(line_dropped), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Three-word line A,B,C
    push(32'hA0A0_0001, 1'b0);
    push(32'hB0B0_0002, 1'b0);
    push(32'hC0C0_0003, 1'b1);
    wait_show("t1_show");
    check("t1_count", 64'(pixel_count), 64'd3);
    read_px(8'd2);
    check("t1_px2", 64'(pixel), {31'd0, 1'b1, 32'hC0C0_0003});
    read_px(8'd0);
    check("t1_px0", 64'(pixel), {31'd0, 1'b1, 32'hA0A0_0001});
    read_px(8'd3);
    check("t1_oor", 64'(pixel[32]), 64'd0);
    check("t1_nr_count", 64'(pixel_count_nr), 64'd3);

    // Session end with nothing pending: resend vs idle
    pulse_done_count(hold_n);
    check("t4_hold_len", 64'(hold_n), 64'(RC));
    check("t4_count", 64'(pixel_count), 64'd3);
    check("t4_nr_tx_rst", 64'(tx_rst_nr), 64'd1);
    check("t4_nr_count", 64'(pixel_count_nr), 64'd3);
    repeat (5) @(negedge clk);
    check("t4_nr_stay", 64'(tx_rst_nr), 64'd1);
    check("t4_show", 64'(tx_rst), 64'd0);

    // Second line committed mid-session waits for the session end
    push(32'hD000_0000, 1'b0);
    push(32'hD000_0001, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_blocked", 64'(wr_ready), 64'd0);
    check("t3_count_hold", 64'(pixel_count), 64'd3);
    check("t3_no_tear", 64'(tx_rst), 64'd0);
    pulse_done_count(hold_n);
    check("t3_hold_len", 64'(hold_n), 64'(RC));
    check("t3_count", 64'(pixel_count), 64'd2);
    read_px(8'd1);
    check("t3_px1", 64'(pixel), {31'd0, 1'b1, 32'hD000_0001});
    check("t3_ready", 64'(wr_ready), 64'd1);

    // Commit coinciding with the swap is dropped
    push(32'hE000_0000, 1'b0);
    push(32'hE000_0001, 1'b0);
    push(32'hE000_0002, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 32'hF000_000F;
    wr_last  = 1'b1;
    tx_done  = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    tx_done  = 1'b0;
    check("t5_dropped", 64'(line_dropped), 64'd1);
    check("t5_tx_rst", 64'(tx_rst), 64'd1);
    @(negedge clk);
    check("t5_drop_pulse", 64'(line_dropped), 64'd0);
    wait_show("t5_show");
    check("t5_count", 64'(pixel_count), 64'd3);
    read_px(8'd2);
    check("t5_px2", 64'(pixel), {31'd0, 1'b1, 32'hE000_0002});
    read_px(8'd1);
    check("t5_px1", 64'(pixel), {31'd0, 1'b1, 32'hE000_0001});
    pulse_done_count(hold_n);
    check("t5_resend_count", 64'(pixel_count), 64'd3);

    // Full-depth line with no wr_last auto-commits
    check("t2_ready_pre", 64'(wr_ready), 64'd1);
    for (int i = 0; i < 256; i++) push(32'h1000_0000 + 32'(i), 1'b0);
    repeat (2) @(negedge clk);
    check("t2_pending", 64'(wr_ready), 64'd0);
    pulse_done_count(hold_n);
    wait_show("t2_show");
    check("t2_count", 64'(pixel_count), 64'd256);
    read_px(8'd255);
    check("t2_px255", 64'(pixel), {31'd0, 1'b1, 32'h1000_00FF});
    read_px(8'd0);
    check("t2_px0", 64'(pixel), {31'd0, 1'b1, 32'h1000_0000});
    check("t2_ready_post", 64'(wr_ready), 64'd1);

    // Reset mid-line during a session
    for (int i = 0; i < 5; i++) push(32'h5500_0000 + 32'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tx_rst", 64'(tx_rst), 64'd1);
    check("t6_ready", 64'(wr_ready), 64'd1);
    check("t6_count", 64'(pixel_count), 64'd0);
    check("t6_dropped", 64'(line_dropped), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    push(32'h6666_0006, 1'b1);
    wait_show("t6_show");
    check("t6_count1", 64'(pixel_count), 64'd1);
    read_px(8'd0);
    check("t6_px0", 64'(pixel), {31'd0, 1'b1, 32'h6666_0006});
    read_px(8'd1);
    check("t6_oor", 64'(pixel[32]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
